// File: rtl/anti_theft_fsm.sv
// Vehicle anti-theft controller: synchronizes the ignition and door switches,
// sequences arm/trigger/alarm states and drives an external countdown timer.
module anti_theft_fsm #(
  parameter logic [3:0] T_ARM_DELAY       = 4'd6,
  parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
  parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic       start_timer,
  output logic [3:0] duration,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ARMED       = 3'd0,
    TRIGGERED   = 3'd1,
    SOUND_ALARM = 3'd2,
    ALARM_HOLD  = 3'd3,
    DISARMED    = 3'd4,
    WAIT_CLOSE  = 3'd5,
    ARM_DELAY   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ign_sync, drv_sync, pas_sync;
  logic       ign_s, drv_s, pas_s;
  logic [1:0] age_q;
  logic       expired_q;
  logic       start_d;
  logic [3:0] duration_d;
  logic       siren_d;
  logic       led_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ign_sync <= 2'b00;
      drv_sync <= 2'b00;
      pas_sync <= 2'b00;
    end else begin
      ign_sync <= {ign_sync[0], ignition};
      drv_sync <= {drv_sync[0], driver_door};
      pas_sync <= {pas_sync[0], passenger_door};
    end
  end

  assign ign_s = ign_sync[1];
  assign drv_s = drv_sync[1];
  assign pas_s = pas_sync[1];

  // Cycles spent in the current state, saturating at 2: the start_timer cycle
  // and one guard cycle ignore expired, which may still be high from the last run.
  assign expired_q = expired && (age_q == 2'd2);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    duration_d = duration;
    start_d    = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (ign_s) begin
          state_d = DISARMED;
        end else if (drv_s) begin
          state_d    = TRIGGERED;
          duration_d = T_DRIVER_DELAY;
          start_d    = 1'b1;
        end else if (pas_s) begin
          state_d    = TRIGGERED;
          duration_d = T_PASSENGER_DELAY;
          start_d    = 1'b1;
        end
      end
      TRIGGERED: begin
        if (ign_s)          state_d = DISARMED;
        else if (expired_q) state_d = SOUND_ALARM;
      end
      SOUND_ALARM: begin
        if (ign_s) begin
          state_d = DISARMED;
        end else if (!drv_s && !pas_s) begin
          state_d    = ALARM_HOLD;
          duration_d = T_ALARM_ON;
          start_d    = 1'b1;
        end
      end
      ALARM_HOLD: begin
        if (ign_s)               state_d = DISARMED;
        else if (drv_s || pas_s) state_d = SOUND_ALARM;
        else if (expired_q)      state_d = ARMED;
      end
      DISARMED: begin
        if (!ign_s && drv_s) state_d = WAIT_CLOSE;
      end
      WAIT_CLOSE: begin
        if (ign_s) begin
          state_d = DISARMED;
        end else if (!drv_s && !pas_s) begin
          state_d    = ARM_DELAY;
          duration_d = T_ARM_DELAY;
          start_d    = 1'b1;
        end
      end
      ARM_DELAY: begin
        if (ign_s)               state_d = DISARMED;
        else if (drv_s || pas_s) state_d = WAIT_CLOSE;
        else if (expired_q)      state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_comb begin
    siren_d = (state_d == SOUND_ALARM) || (state_d == ALARM_HOLD);
    led_d   = 1'b0;
    if (state_d == ARMED) begin
      if (state_q != ARMED) led_d = 1'b0;
      else if (one_hz_enable) led_d = ~status_led;
      else led_d = status_led;
    end else if (state_d == TRIGGERED || state_d == SOUND_ALARM ||
                 state_d == ALARM_HOLD) begin
      led_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARMED;
      age_q       <= 2'd0;
      start_timer <= 1'b0;
      duration    <= 4'd0;
      siren       <= 1'b0;
      status_led  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_timer <= start_d;
      duration    <= duration_d;
      siren       <= siren_d;
      status_led  <= led_d;
      if (state_d != state_q) age_q <= 2'd0;
      else if (age_q != 2'd2) age_q <= age_q + 2'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed bench for anti_theft_fsm: stimulus queues the expected outputs of
// each state change; a negedge monitor pops and compares them as they occur.
module tb_anti_theft_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ignition = 1'b0;
  logic       driver_door = 1'b0;
  logic       passenger_door = 1'b0;
  logic       expired = 1'b0;
  logic       one_hz_enable = 1'b0;
  logic       start_timer;
  logic [3:0] duration;
  logic       siren;
  logic       status_led;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       start;
    logic [3:0] dur;
    logic       siren;
    logic       led;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [2:0] S_ARMED = 3'd0, S_TRIG = 3'd1, S_SOUND = 3'd2,
                         S_HOLD = 3'd3, S_DIS = 3'd4, S_WAIT = 3'd5,
                         S_ADLY = 3'd6;

  anti_theft_fsm dut (
    .clk            (clk),
    .rst            (rst),
    .ignition       (ignition),
    .driver_door    (driver_door),
    .passenger_door (passenger_door),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .start_timer    (start_timer),
    .duration       (duration),
    .siren          (siren),
    .status_led     (status_led),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic start,
                      input logic [3:0] dur, input logic sr, input logic led);
    exp_t e;
    e.st = st; e.start = start; e.dur = dur; e.siren = sr; e.led = led;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every state change must match the next queued expectation;
  // outside state changes start_timer must be low.
  initial begin : monitor
    logic [2:0] prev;
    exp_t       e;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (state != prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_state_change", {29'd0, state}, {29'd0, prev});
          end else begin
            e = exp_q.pop_front();
            check("sb_state",       {29'd0, state},       {29'd0, e.st});
            check("sb_start_timer", {31'd0, start_timer}, {31'd0, e.start});
            check("sb_duration",    {28'd0, duration},    {28'd0, e.dur});
            check("sb_siren",       {31'd0, siren},       {31'd0, e.siren});
            check("sb_status_led",  {31'd0, status_led},  {31'd0, e.led});
          end
        end else begin
          check("start_timer_idle", {31'd0, start_timer}, 32'd0);
        end
      end
      prev = state;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stimulus
    tick(3);
    check("rst_state",       {29'd0, state},       32'd0);
    check("rst_start_timer", {31'd0, start_timer}, 32'd0);
    check("rst_duration",    {28'd0, duration},    32'd0);
    check("rst_siren",       {31'd0, siren},       32'd0);
    check("rst_status_led",  {31'd0, status_led},  32'd0);
    rst = 1'b0;
    tick(2);

    // Driver door in ARMED: three-edge latency, timer loaded with 8.
    push(S_TRIG, 1'b1, 4'd8, 1'b0, 1'b1);
    driver_door = 1'b1;
    tick(1); check("latency_edge1", {29'd0, state}, {29'd0, S_ARMED});
    tick(1); check("latency_edge2", {29'd0, state}, {29'd0, S_ARMED});
    tick(1); check("latency_edge3", {29'd0, state}, {29'd0, S_TRIG});
    tick(3);

    // Ignition before expiry disarms; siren never sounds.
    push(S_DIS, 1'b0, 4'd8, 1'b0, 1'b0);
    ignition = 1'b1;
    tick(5);
    check("disarmed_led", {31'd0, status_led}, 32'd0);

    // Ignition off with driver door open, then door cycles through arm delay.
    push(S_WAIT, 1'b0, 4'd8, 1'b0, 1'b0);
    ignition = 1'b0;
    tick(5);
    push(S_ADLY, 1'b1, 4'd6, 1'b0, 1'b0);
    driver_door = 1'b0;
    tick(5);
    push(S_WAIT, 1'b0, 4'd6, 1'b0, 1'b0);
    passenger_door = 1'b1;
    tick(5);
    push(S_ADLY, 1'b1, 4'd6, 1'b0, 1'b0);
    passenger_door = 1'b0;
    tick(6);
    push(S_ARMED, 1'b0, 4'd6, 1'b0, 1'b0);
    expired = 1'b1;
    tick(1);
    check("armed_after_delay", {29'd0, state}, {29'd0, S_ARMED});
    expired = 1'b0;
    tick(2);

    // Blink: each one_hz_enable toggles status_led while armed.
    one_hz_enable = 1'b1; tick(1); one_hz_enable = 1'b0;
    check("blink_on", {31'd0, status_led}, 32'd1);
    tick(3);
    check("blink_hold", {31'd0, status_led}, 32'd1);
    one_hz_enable = 1'b1; tick(1); one_hz_enable = 1'b0;
    check("blink_off", {31'd0, status_led}, 32'd0);
    tick(2);

    // Both doors with stale expired high: driver delay wins; expired is ignored
    // through the start_timer and guard cycles.
    push(S_TRIG,  1'b1, 4'd8, 1'b0, 1'b1);
    push(S_SOUND, 1'b0, 4'd8, 1'b1, 1'b1);
    driver_door = 1'b1; passenger_door = 1'b1; expired = 1'b1;
    tick(3); check("stale_exp_entry", {29'd0, state}, {29'd0, S_TRIG});
    tick(1); check("stale_exp_cyc1",  {29'd0, state}, {29'd0, S_TRIG});
    tick(1); check("stale_exp_guard", {29'd0, state}, {29'd0, S_TRIG});
    tick(1); check("qualified_exp",   {29'd0, state}, {29'd0, S_SOUND});
    check("sound_siren", {31'd0, siren}, 32'd1);
    expired = 1'b0;
    tick(3);

    // Alarm hold: reopen returns to sound, close again and expire to ARMED.
    push(S_HOLD, 1'b1, 4'd10, 1'b1, 1'b1);
    driver_door = 1'b0; passenger_door = 1'b0;
    tick(5);
    push(S_SOUND, 1'b0, 4'd10, 1'b1, 1'b1);
    driver_door = 1'b1;
    tick(5);
    push(S_HOLD, 1'b1, 4'd10, 1'b1, 1'b1);
    driver_door = 1'b0;
    tick(6);
    push(S_ARMED, 1'b0, 4'd10, 1'b0, 1'b0);
    expired = 1'b1;
    tick(1);
    check("hold_expired_armed", {29'd0, state}, {29'd0, S_ARMED});
    check("hold_expired_siren", {31'd0, siren}, 32'd0);
    expired = 1'b0;
    tick(3);

    // Passenger door alone: 15 s delay; closing it does not restart anything.
    push(S_TRIG, 1'b1, 4'd15, 1'b0, 1'b1);
    passenger_door = 1'b1;
    tick(5);
    passenger_door = 1'b0;
    tick(5);
    check("trig_hold", {29'd0, state}, {29'd0, S_TRIG});

    // Reset mid-countdown.
    rst = 1'b1;
    tick(1);
    check("midrst_state",       {29'd0, state},       32'd0);
    check("midrst_start_timer", {31'd0, start_timer}, 32'd0);
    check("midrst_duration",    {28'd0, duration},    32'd0);
    check("midrst_siren",       {31'd0, siren},       32'd0);
    check("midrst_status_led",  {31'd0, status_led},  32'd0);
    tick(1);
    rst = 1'b0;
    tick(5);
    check("post_rst_state", {29'd0, state}, {29'd0, S_ARMED});

    tick(2);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/anti_theft_fsm.md
ANTI_THEFT_FSM -- requirements
Module: anti_theft_fsm

Interface
REQ-001 SHALL have parameter T_ARM_DELAY, default 4'd6, arming delay in seconds.
REQ-002 SHALL have parameter T_DRIVER_DELAY, default 4'd8, driver-door entry delay in seconds.
REQ-003 SHALL have parameter T_PASSENGER_DELAY, default 4'd15, passenger-door entry delay in seconds.
REQ-004 SHALL have parameter T_ALARM_ON, default 4'd10, siren hold time after doors close, in seconds.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port ignition, input, 1, asynchronous switch; 1 = ignition on.
REQ-008 SHALL have port driver_door, input, 1, asynchronous switch; 1 = door open.
REQ-009 SHALL have port passenger_door, input, 1, asynchronous switch; 1 = door open.
REQ-010 SHALL have port expired, input, 1, timer countdown complete (level).
REQ-011 SHALL have port one_hz_enable, input, 1, one-cycle tick each second from the timer.
REQ-012 SHALL have port start_timer, output, 1, one-cycle timer load pulse.
REQ-013 SHALL have port duration, output, 4, seconds for the timer; valid whenever start_timer = 1, held until the next start_timer.
REQ-014 SHALL have port siren, output, 1, alarm sounder.
REQ-015 SHALL have port status_led, output, 1, status indicator.
REQ-016 SHALL have port state, output, 3, current state code (debug).

Function
REQ-017 SHALL pass ignition, driver_door and passenger_door through a 2-flop synchronizer; the FSM uses only the synchronized values (ign_s, drv_s, pas_s).
REQ-018 SHALL implement the following states: ARMED=0, TRIGGERED=1, SOUND_ALARM=2, ALARM_HOLD=3, DISARMED=4, WAIT_CLOSE=5, ARM_DELAY=6; codes 7 SHALL recover to ARMED on the next edge.
REQ-019 SHALL apply transition priority per cycle: ign_s=1 first, then door events, then qualified expired.
REQ-020 SHALL move every state except DISARMED to DISARMED when ign_s=1.
REQ-021 ARMED: drv_s=1 SHALL go to TRIGGERED with duration=T_DRIVER_DELAY; otherwise pas_s=1 SHALL go to TRIGGERED with duration=T_PASSENGER_DELAY; if both are open, the driver delay SHALL be used.
REQ-022 TRIGGERED: qualified expired SHALL go to SOUND_ALARM; door activity SHALL NOT restart the timer.
REQ-023 SOUND_ALARM: drv_s=0 and pas_s=0 SHALL go to ALARM_HOLD with duration=T_ALARM_ON.
REQ-024 ALARM_HOLD: any door open SHALL return to SOUND_ALARM; otherwise qualified expired SHALL go to ARMED.
REQ-025 DISARMED: ign_s=0 and drv_s=1 SHALL go to WAIT_CLOSE.
REQ-026 WAIT_CLOSE: drv_s=0 and pas_s=0 SHALL go to ARM_DELAY with duration=T_ARM_DELAY.
REQ-027 ARM_DELAY: any door open SHALL return to WAIT_CLOSE; otherwise qualified expired SHALL go to ARMED.
REQ-028 start_timer SHALL be registered and high exactly in the first cycle of TRIGGERED, ALARM_HOLD and ARM_DELAY; it SHALL never be high in consecutive cycles.
REQ-029 expired SHALL be qualified only from the third cycle of a timed state onward (start_timer cycle plus one guard cycle ignored), so stale expired never causes a transition.
REQ-030 Latency: a switch change SHALL be reflected on state at the third rising edge after it is stable.
REQ-031 siren SHALL be 1 only in SOUND_ALARM and ALARM_HOLD; it SHALL be a registered output decoded from the next state.
REQ-032 status_led: ARMED SHALL toggle it on each one_hz_enable (0.5 Hz blink); TRIGGERED, SOUND_ALARM and ALARM_HOLD SHALL drive 1; the other states SHALL drive 0.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL set: state=ARMED, start_timer=0, duration=4'd0, siren=0, status_led=0, and all synchronizer flops to 0.
REQ-034 Reset SHALL take priority over all inputs, including mid-countdown, and SHALL issue no start_timer pulse on exit.

Verification
REQ-035 Reset, then drv_s rises in ARMED -> TRIGGERED; start_timer pulses once with duration=8.
REQ-036 Both doors open simultaneously in ARMED -> duration=8; expired asserted 8 s later -> SOUND_ALARM with siren=1.
REQ-037 SOUND_ALARM, then doors close -> ALARM_HOLD, duration=10; door reopens before expired -> SOUND_ALARM; close again and wait for expiry -> ARMED with siren=0.
REQ-038 Ignition on during TRIGGERED before expiry -> DISARMED; siren never asserts; status_led=0.
REQ-039 DISARMED with ignition off: driver door opens and closes -> ARM_DELAY, duration=6; passenger door opens mid-delay -> WAIT_CLOSE; close and wait for expiry -> ARMED, status_led toggles on each one_hz_enable.
REQ-040 Expired held high at entry to TRIGGERED -> state stays TRIGGERED through the start_timer cycle and the guard cycle; rst asserted mid-countdown -> ARMED with all outputs at reset values on the next edge.
